// File: rtl/palette_pkg.sv
// Shared types and constants for the palette arbiter: index width, ROM address
// width, backdrop address, port ids and the result tag carried down the pipeline.
package palette_pkg;

  localparam int unsigned IDX_W  = 4;
  localparam int unsigned ROM_AW = 5;

  localparam logic [ROM_AW-1:0] BACKDROP_ADDR = 5'h00;

  typedef enum logic {
    PORT_BG  = 1'b0,
    PORT_SPR = 1'b1
  } port_e;

  typedef struct packed {
    logic  vld;
    port_e port;
  } tag_t;

  // Colour 0 of every sub-palette aliases the shared backdrop entry.
  function automatic logic [ROM_AW-1:0] pal_addr(input port_e port,
                                                 input logic [IDX_W-1:0] idx);
    if (idx[1:0] == 2'b00) begin
      return BACKDROP_ADDR;
    end
    return ROM_AW'({port, idx});
  endfunction

endpackage

// File: rtl/palette_arb_sel.sv
// Grant selection between background and sprite requesters.
// Define PALETTE_RR_EN for round-robin on contention; default is sprite priority.
import palette_pkg::*;

module palette_arb_sel (
`ifdef PALETTE_RR_EN
  input  logic clk,
  input  logic rst,
`endif
  input  logic bg_req,
  input  logic spr_req,
  output logic bg_gnt_c,
  output logic spr_gnt_c
);

`ifdef PALETTE_RR_EN
  // rr_q names the port that wins the next contended cycle.
  port_e rr_q;
  port_e rr_d;

  always_comb begin
    rr_d      = rr_q;
    bg_gnt_c  = 1'b0;
    spr_gnt_c = 1'b0;
    if (bg_req && spr_req) begin
      if (rr_q == PORT_BG) begin
        bg_gnt_c = 1'b1;
        rr_d     = PORT_SPR;
      end else begin
        spr_gnt_c = 1'b1;
        rr_d      = PORT_BG;
      end
    end else begin
      bg_gnt_c  = bg_req;
      spr_gnt_c = spr_req;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_q <= PORT_BG;
    end else begin
      rr_q <= rr_d;
    end
  end
`else
  always_comb begin
    spr_gnt_c = spr_req;
    bg_gnt_c  = bg_req & ~spr_req;
  end
`endif

endmodule

// File: rtl/palette_arb_ctrl.sv
// Palette ROM arbiter: one lookup per cycle, result valid two cycles after grant.
// Optional macro PALETTE_RR_EN selects round-robin instead of sprite priority.
import palette_pkg::*;

module palette_arb_ctrl #(
  parameter int unsigned IDX_W  = palette_pkg::IDX_W,
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              bg_req,
  input  logic [IDX_W-1:0]  bg_idx,
  output logic              bg_gnt,
  output logic              bg_vld,
  output logic [DATA_W-1:0] bg_data,
  input  logic              spr_req,
  input  logic [IDX_W-1:0]  spr_idx,
  output logic              spr_gnt,
  output logic              spr_vld,
  output logic [DATA_W-1:0] spr_data,
  output logic [ROM_AW-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_dout
);

  logic sel_bg_gnt;
  logic sel_spr_gnt;

  palette_arb_sel u_sel (
`ifdef PALETTE_RR_EN
    .clk       (clk),
    .rst       (rst),
`endif
    .bg_req    (bg_req),
    .spr_req   (spr_req),
    .bg_gnt_c  (sel_bg_gnt),
    .spr_gnt_c (sel_spr_gnt)
  );

  // Grants are suppressed while reset is held so nothing is consumed.
  assign bg_gnt  = sel_bg_gnt & ~rst;
  assign spr_gnt = sel_spr_gnt & ~rst;

  logic [ROM_AW-1:0] addr_q, addr_d;
  tag_t              s1_q, s1_d;
  tag_t              s2_q, s2_d;
  logic [DATA_W-1:0] bg_data_q, bg_data_d;
  logic [DATA_W-1:0] spr_data_q, spr_data_d;

  always_comb begin
    addr_d     = addr_q;
    s1_d       = '0;
    s2_d       = s1_q;
    bg_data_d  = bg_data_q;
    spr_data_d = spr_data_q;
    if (spr_gnt) begin
      addr_d = pal_addr(PORT_SPR, spr_idx);
      s1_d   = '{vld: 1'b1, port: PORT_SPR};
    end else if (bg_gnt) begin
      addr_d = pal_addr(PORT_BG, bg_idx);
      s1_d   = '{vld: 1'b1, port: PORT_BG};
    end
    // ROM output belongs to the stage-1 tag's port.
    if (s1_q.vld) begin
      if (s1_q.port == PORT_BG) begin
        bg_data_d = rom_dout;
      end else begin
        spr_data_d = rom_dout;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q     <= '0;
      s1_q       <= '0;
      s2_q       <= '0;
      bg_data_q  <= '0;
      spr_data_q <= '0;
    end else begin
      addr_q     <= addr_d;
      s1_q       <= s1_d;
      s2_q       <= s2_d;
      bg_data_q  <= bg_data_d;
      spr_data_q <= spr_data_d;
    end
  end

  assign rom_addr = addr_d;
  assign bg_vld   = s2_q.vld && (s2_q.port == PORT_BG);
  assign spr_vld  = s2_q.vld && (s2_q.port == PORT_SPR);
  assign bg_data  = bg_data_q;
  assign spr_data = spr_data_q;

endmodule
